// File: rtl/mpc_pkg.sv
// mpc_pkg: shared definitions for the mpc sequencer.
//   - default datapath/opcode widths and bus-timeout limit
//   - opcode values of the 12-bit ISA (opcode in the top OPW bits)
//   - sequencer state encoding
//   - ERR output codes
package mpc_pkg;

    localparam int DW_DEF  = 12;
    localparam int OPW_DEF = 4;
    localparam int TMO_DEF = 15;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;  // A <= next word
    localparam logic [3:0] OP_LDB  = 4'h2;  // B <= next word
    localparam logic [3:0] OP_ADD  = 4'h3;  // A <= A + B
    localparam logic [3:0] OP_ADC  = 4'h4;  // A <= A + B + CFLAG
    localparam logic [3:0] OP_JMP  = 4'h5;  // PC <= next word
    localparam logic [3:0] OP_JC   = 4'h6;  // PC <= next word if CFLAG
    localparam logic [3:0] OP_LDX  = 4'h7;  // A <= mem[B]
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_OPER   = 3'd3,
        ST_IND    = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/mpc_seq_timeout.sv
// mpc_seq_timeout: memory wait-cycle counter for the sequencer.
//   clk      in  clock
//   rst      in  asynchronous active-high reset
//   clr      in  restart the count (sequencer entering a new state)
//   en       in  one more cycle spent waiting for MEM_RDY
//   expired  out TMO-1 wait cycles already spent: a further wait this
//                cycle is the TMO-th and ends the access
module mpc_seq_timeout #(
    parameter int TMO = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [CW-1:0] LAST = CW'(TMO - 1);

    logic [CW-1:0] count_reg;

    // Saturates at LAST; the sequencer leaves the wait state on that cycle
    // either way (data accepted or timeout), so it never needs to go higher.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != LAST)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == LAST);

endmodule

// File: rtl/mpc_sequencer.sv
// mpc_sequencer: fetch/decode/execute control unit for the 12-bit mpc datapath.
//   CLK, RESET (async, active-high), START (resume pulse)
//   INSTR      memory read data (also the datapath DATA_IN bus)
//   MEM_RDY    read data valid; OVF datapath adder carry-out
//   MEM_RD     read request, held until MEM_RDY or timeout
//   CTRL_ADDR  address select (0 PC, 1 B); CTRL_A A source (1 DATA_IN, 0 adder)
//   CTRL_PC    PC source (0 PC+1, 1 DATA_IN); WE_A/WE_B/WE_PC write enables; CIN
//   BUSY       running; HALTED in HALT; ERR 00 none / 01 illegal / 10 timeout
// Outputs are combinational from state, IR, CFLAG and MEM_RDY so the
// datapath acts on them at the same clock edge the sequencer advances.
module mpc_sequencer
    import mpc_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int OPW = OPW_DEF,
    parameter int TMO = TMO_DEF
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          START,
    input  logic [DW-1:0] INSTR,
    input  logic          MEM_RDY,
    input  logic          OVF,
    output logic          MEM_RD,
    output logic          CTRL_ADDR,
    output logic          CTRL_A,
    output logic          CTRL_PC,
    output logic          WE_A,
    output logic          WE_B,
    output logic          WE_PC,
    output logic          CIN,
    output logic          BUSY,
    output logic          HALTED,
    output logic [1:0]    ERR
);

    state_t         state_reg;
    state_t         state_next;
    logic [OPW-1:0] ir_reg;      // only the opcode field is ever decoded
    logic [OPW-1:0] ir_next;
    logic           cflag_reg;
    logic           cflag_next;
    logic [1:0]     err_reg;
    logic [1:0]     err_next;

    logic           wait_state;
    logic           tmo_clr;
    logic           tmo_en;
    logic           tmo_expired;

    // Operand/low bits of the opcode word carry no meaning here.
    logic           unused_instr_bits;
    assign unused_instr_bits = ^INSTR[DW-OPW-1:0];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= ST_IDLE;
            ir_reg    <= '0;
            cflag_reg <= 1'b0;
            err_reg   <= ERR_NONE;
        end else begin
            state_reg <= state_next;
            ir_reg    <= ir_next;
            cflag_reg <= cflag_next;
            err_reg   <= err_next;
        end
    end

    // Wait counter restarts on every state change, so each of FETCH, OPER
    // and IND begins its memory access with a fresh budget.
    assign wait_state = (state_reg == ST_FETCH) || (state_reg == ST_OPER) ||
                        (state_reg == ST_IND);
    assign tmo_en     = wait_state && !MEM_RDY;
    assign tmo_clr    = (state_next != state_reg);

    mpc_seq_timeout #(
        .TMO (TMO)
    ) u_timeout (
        .clk     (CLK),
        .rst     (RESET),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_comb begin
        state_next = state_reg;
        ir_next    = ir_reg;
        cflag_next = cflag_reg;
        err_next   = err_reg;
        MEM_RD     = 1'b0;
        CTRL_ADDR  = 1'b0;
        CTRL_A     = 1'b0;
        CTRL_PC    = 1'b0;
        WE_A       = 1'b0;
        WE_B       = 1'b0;
        WE_PC      = 1'b0;
        CIN        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (START) begin
                    err_next   = ERR_NONE;
                    state_next = ST_FETCH;
                end
            end

            ST_FETCH: begin
                MEM_RD = 1'b1;
                if (MEM_RDY) begin
                    ir_next    = INSTR[DW-1 -: OPW];
                    WE_PC      = 1'b1;          // PC <= PC + 1
                    state_next = ST_DECODE;
                end else if (tmo_expired) begin
                    err_next   = ERR_TIMEOUT;
                    state_next = ST_HALT;
                end
            end

            ST_DECODE: begin
                state_next = ST_FETCH;
                case (ir_reg)
                    OP_NOP: ;
                    OP_ADD: begin
                        WE_A       = 1'b1;      // A <= A + B
                        cflag_next = OVF;
                    end
                    OP_ADC: begin
                        WE_A       = 1'b1;
                        CIN        = cflag_reg;
                        cflag_next = OVF;
                    end
                    OP_LDA, OP_LDB, OP_JMP, OP_JC: state_next = ST_OPER;
                    OP_LDX:  state_next = ST_IND;
                    OP_HALT: state_next = ST_HALT;
                    default: begin
                        err_next   = ERR_ILLEGAL;
                        state_next = ST_HALT;
                    end
                endcase
            end

            ST_OPER: begin
                MEM_RD = 1'b1;
                if (MEM_RDY) begin
                    state_next = ST_FETCH;
                    WE_PC      = 1'b1;
                    case (ir_reg)
                        OP_LDA: begin
                            WE_A   = 1'b1;
                            CTRL_A = 1'b1;
                        end
                        OP_LDB:  WE_B    = 1'b1;
                        OP_JMP:  CTRL_PC = 1'b1;
                        // Not taken still steps PC over the operand word.
                        OP_JC:   CTRL_PC = cflag_reg;
                        default: ;
                    endcase
                end else if (tmo_expired) begin
                    err_next   = ERR_TIMEOUT;
                    state_next = ST_HALT;
                end
            end

            ST_IND: begin
                MEM_RD    = 1'b1;
                CTRL_ADDR = 1'b1;
                if (MEM_RDY) begin
                    WE_A       = 1'b1;
                    CTRL_A     = 1'b1;
                    state_next = ST_FETCH;
                end else if (tmo_expired) begin
                    err_next   = ERR_TIMEOUT;
                    state_next = ST_HALT;
                end
            end

            ST_HALT: begin
                if (START) begin
                    err_next   = ERR_NONE;
                    state_next = ST_FETCH;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    assign BUSY   = (state_reg != ST_IDLE) && (state_reg != ST_HALT);
    assign HALTED = (state_reg == ST_HALT);
    assign ERR    = err_reg;

endmodule

// File: tb/tb_mpc_sequencer.sv
module tb_mpc_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic [11:0] INSTR;
    logic        MEM_RDY = 1'b0;
    logic        OVF;
    logic        MEM_RD, CTRL_ADDR, CTRL_A, CTRL_PC, WE_A, WE_B, WE_PC, CIN, BUSY, HALTED;
    logic [1:0]  ERR;

    mpc_sequencer #(.DW(12), .OPW(4), .TMO(15)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .INSTR(INSTR), .MEM_RDY(MEM_RDY),
        .OVF(OVF), .MEM_RD(MEM_RD), .CTRL_ADDR(CTRL_ADDR), .CTRL_A(CTRL_A),
        .CTRL_PC(CTRL_PC), .WE_A(WE_A), .WE_B(WE_B), .WE_PC(WE_PC), .CIN(CIN),
        .BUSY(BUSY), .HALTED(HALTED), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // ---------------- datapath + memory environment ----------------
    logic [11:0] mem [0:4095];
    logic [11:0] a_reg = 12'd0, b_reg = 12'd0, pc_reg = 12'd0;
    logic [11:0] bus_addr, data_in;
    logic [12:0] sum;
    assign bus_addr = CTRL_ADDR ? b_reg : pc_reg;
    assign data_in  = mem[bus_addr];
    assign INSTR    = data_in;
    assign sum      = {1'b0, a_reg} + {1'b0, b_reg} + {12'd0, CIN};
    assign OVF      = sum[12];

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            a_reg <= 12'd0; b_reg <= 12'd0; pc_reg <= 12'd0;
        end else begin
            if (WE_A)  a_reg  <= CTRL_A ? data_in : sum[11:0];
            if (WE_B)  b_reg  <= data_in;
            if (WE_PC) pc_reg <= CTRL_PC ? data_in : pc_reg + 12'd1;
        end
    end

    // MEM_RDY: per read, cur_delay idle cycles then one ready cycle.
    int delay_mode = 0;      // <0: random 0..3 per read
    bit never_rdy  = 1'b0;
    int wcnt = 0, cur_delay = 0;
    always @(posedge CLK) begin
        #1;
        if (!MEM_RD) begin
            MEM_RDY   = 1'b0;
            wcnt      = 0;
            cur_delay = (delay_mode < 0) ? int'($urandom_range(0, 3)) : delay_mode;
        end else if (never_rdy) begin
            MEM_RDY = 1'b0;
        end else if (wcnt >= cur_delay) begin
            MEM_RDY   = 1'b1;
            wcnt      = 0;
            cur_delay = (delay_mode < 0) ? int'($urandom_range(0, 3)) : delay_mode;
        end else begin
            MEM_RDY = 1'b0;
            wcnt++;
        end
    end

    // Bus monitor (sampled mid-cycle), monotonic logs.
    logic [11:0] rd_q [$];
    logic        cin_q [$];
    int rd_high_cnt = 0, wait_we_cnt = 0, ab_cnt = 0, jump_cnt = 0, ind_cnt = 0;
    always @(negedge CLK) begin
        if (!RESET) begin
            if (MEM_RD) rd_high_cnt++;
            if (MEM_RD && !MEM_RDY && (WE_A || WE_B || WE_PC)) wait_we_cnt++;
            if (MEM_RD && MEM_RDY) rd_q.push_back(bus_addr);
            if (WE_A && !CTRL_A) cin_q.push_back(CIN);
            if (WE_A || WE_B) ab_cnt++;
            if (WE_PC && CTRL_PC) jump_cnt++;
            if (CTRL_ADDR && MEM_RD) ind_cnt++;
        end
    end

    // ---------------- reference ISA model ----------------
    logic [11:0] exp_rd [$];
    logic        exp_cin [$];
    logic [11:0] exp_a, exp_b, exp_pc;
    logic [1:0]  exp_err;
    int          exp_jumps;

    task automatic model_run();
        logic [11:0] a, b, pc;
        logic        c;
        logic [12:0] s;
        logic [3:0]  op;
        bit          done;
        int          steps;
        a = 0; b = 0; pc = 0; c = 0; done = 0; steps = 0;
        exp_rd.delete(); exp_cin.delete(); exp_jumps = 0; exp_err = 2'b00;
        while (!done && steps < 1000) begin
            steps++;
            exp_rd.push_back(pc);
            op = mem[pc][11:8];
            pc = pc + 1;
            case (op)
                4'h0: ;
                4'h1: begin exp_rd.push_back(pc); a = mem[pc]; pc = pc + 1; end
                4'h2: begin exp_rd.push_back(pc); b = mem[pc]; pc = pc + 1; end
                4'h3: begin s = {1'b0, a} + {1'b0, b}; a = s[11:0]; c = s[12]; exp_cin.push_back(1'b0); end
                4'h4: begin exp_cin.push_back(c); s = {1'b0, a} + {1'b0, b} + {12'd0, c}; a = s[11:0]; c = s[12]; end
                4'h5: begin exp_rd.push_back(pc); pc = mem[pc]; exp_jumps++; end
                4'h6: begin
                    exp_rd.push_back(pc);
                    if (c) begin pc = mem[pc]; exp_jumps++; end
                    else pc = pc + 1;
                end
                4'h7: begin exp_rd.push_back(b); a = mem[b]; end
                4'hF: done = 1;
                default: begin exp_err = 2'b01; done = 1; end
            endcase
        end
        exp_a = a; exp_b = b; exp_pc = pc;
    endtask

    // ---------------- helpers ----------------
    int total = 0, bad = 0;
    int rd_base, cin_base, rdh_base, wwe_base, ab_base, jmp_base, ind_base;

    task automatic snap();
        rd_base = rd_q.size(); cin_base = cin_q.size(); rdh_base = rd_high_cnt;
        wwe_base = wait_we_cnt; ab_base = ab_cnt; jmp_base = jump_cnt; ind_base = ind_cnt;
    endtask

    function automatic int trace_mismatch();
        int m = 0;
        if (rd_q.size() - rd_base != exp_rd.size()) m++;
        else for (int i = 0; i < exp_rd.size(); i++) if (rd_q[rd_base + i] !== exp_rd[i]) m++;
        if (cin_q.size() - cin_base != exp_cin.size()) m++;
        else for (int i = 0; i < exp_cin.size(); i++) if (cin_q[cin_base + i] !== exp_cin[i]) m++;
        return m;
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom);
    endtask

    task automatic load_prog1();
        fill_mem();
        mem[0] = 12'h100; mem[1] = 12'h007; mem[2] = 12'h200;
        mem[3] = 12'h019; mem[4] = 12'h300; mem[5] = 12'hF00;
    endtask

    task automatic do_reset();
        @(negedge CLK); RESET = 1'b1;
        @(negedge CLK); @(negedge CLK); RESET = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
    endtask

    task automatic wait_halt(input int max_cyc, output bit hung);
        int n = 0;
        while (HALTED !== 1'b1 && n < max_cyc) begin @(negedge CLK); n++; end
        hung = (HALTED !== 1'b1);
    endtask

    task automatic run_prog(output bit hung);
        do_reset(); snap(); pulse_start(); wait_halt(600, hung);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [11:0] outs;
        RESET = 1'b1; #1;
        outs = {MEM_RD, CTRL_ADDR, CTRL_A, CTRL_PC, WE_A, WE_B, WE_PC, CIN, BUSY, HALTED, ERR};
        total++; if (outs !== 12'd0) begin bad++; $display("FAIL reset_outputs: got %b want 0", outs); end
        @(negedge CLK); @(negedge CLK); RESET = 1'b0;
        repeat (3) @(negedge CLK);
        total++; if ({BUSY, HALTED, MEM_RD} !== 3'b000) begin bad++; $display("FAIL reset_idle: got %b want 000", {BUSY, HALTED, MEM_RD}); end
        $display("reset: outputs=%b", outs);
    endtask

    task automatic test_basic(input int dly, input string tag);
        bit hung;
        load_prog1(); model_run(); delay_mode = dly;
        run_prog(hung);
        total++; if (hung) begin bad++; $display("FAIL %s_halt: got halted=%b want 1", tag, HALTED); end
        total++; if (a_reg !== 12'h020) begin bad++; $display("FAIL %s_a: got %h want 020", tag, a_reg); end
        total++; if (b_reg !== 12'h019) begin bad++; $display("FAIL %s_b: got %h want 019", tag, b_reg); end
        total++; if (pc_reg !== 12'h006) begin bad++; $display("FAIL %s_pc: got %h want 006", tag, pc_reg); end
        total++; if ({ERR, BUSY} !== 3'b000) begin bad++; $display("FAIL %s_err_busy: got %b want 000", tag, {ERR, BUSY}); end
        total++; if (trace_mismatch() !== 0) begin bad++; $display("FAIL %s_trace: got %0d mismatches want 0", tag, trace_mismatch()); end
        total++; if (wait_we_cnt - wwe_base !== 0) begin bad++; $display("FAIL %s_we_in_wait: got %0d want 0", tag, wait_we_cnt - wwe_base); end
        total++; if (rd_high_cnt - rdh_base !== 6 * (dly + 1)) begin bad++; $display("FAIL %s_rd_cycles: got %0d want %0d", tag, rd_high_cnt - rdh_base, 6 * (dly + 1)); end
        $display("%s: a=%h b=%h pc=%h rd_cycles=%0d", tag, a_reg, b_reg, pc_reg, rd_high_cnt - rdh_base);
    endtask

    task automatic test_carry();
        bit hung;
        fill_mem();
        mem[0] = 12'h100; mem[1] = 12'hFFF; mem[2] = 12'h200; mem[3] = 12'h001;
        mem[4] = 12'h300; mem[5] = 12'h600; mem[6] = 12'h040;
        mem[12'h040] = 12'h400; mem[12'h041] = 12'hF00;
        model_run(); delay_mode = 0;
        run_prog(hung);
        total++; if (hung) begin bad++; $display("FAIL carry_halt: got halted=%b want 1", HALTED); end
        total++; if (jump_cnt - jmp_base !== 1) begin bad++; $display("FAIL carry_jump: got %0d want 1", jump_cnt - jmp_base); end
        total++; if (rd_q.size() <= rd_base + 7 || rd_q[rd_base + 7] !== 12'h040) begin bad++; $display("FAIL carry_target_fetch: got reads=%0d want fetch 040", rd_q.size() - rd_base); end
        total++; if (cin_q.size() != cin_base + 2 || cin_q[cin_base + 1] !== 1'b1) begin bad++; $display("FAIL carry_adc_cin: got adds=%0d want cin 1 on ADC", cin_q.size() - cin_base); end
        total++; if (a_reg !== 12'h002) begin bad++; $display("FAIL carry_a: got %h want 002", a_reg); end
        total++; if (pc_reg !== 12'h042) begin bad++; $display("FAIL carry_pc: got %h want 042", pc_reg); end
        total++; if (trace_mismatch() !== 0) begin bad++; $display("FAIL carry_trace: got %0d mismatches want 0", trace_mismatch()); end
        $display("carry: a=%h pc=%h jumps=%0d", a_reg, pc_reg, jump_cnt - jmp_base);
    endtask

    task automatic test_timeout();
        bit hung;
        load_prog1(); delay_mode = 0; never_rdy = 1'b1;
        run_prog(hung);
        total++; if (hung || ERR !== 2'b10) begin bad++; $display("FAIL tmo_err: got err=%b halted=%b want 10/1", ERR, HALTED); end
        total++; if (rd_high_cnt - rdh_base !== 15) begin bad++; $display("FAIL tmo_cycles: got %0d want 15", rd_high_cnt - rdh_base); end
        total++; if (BUSY !== 1'b0 || ab_cnt - ab_base !== 0 || pc_reg !== 12'd0) begin bad++; $display("FAIL tmo_nowrite: got busy=%b ab=%0d pc=%h want 0/0/000", BUSY, ab_cnt - ab_base, pc_reg); end
        never_rdy = 1'b0;
        snap(); pulse_start();
        total++; if ({ERR, BUSY} !== 3'b001) begin bad++; $display("FAIL tmo_restart: got err=%b busy=%b want 00/1", ERR, BUSY); end
        wait_halt(600, hung);
        total++; if (hung || a_reg !== 12'h020 || ERR !== 2'b00) begin bad++; $display("FAIL tmo_rerun: got a=%h err=%b want 020/00", a_reg, ERR); end
        $display("timeout: rerun a=%h err=%b", a_reg, ERR);
    endtask

    task automatic test_illegal();
        bit hung;
        for (int op = 8; op <= 14; op++) begin
            fill_mem();
            mem[0] = {4'(op), 8'($urandom)};
            delay_mode = -1;
            run_prog(hung);
            total++; if (hung || ERR !== 2'b01 || ab_cnt - ab_base !== 0 || pc_reg !== 12'd1) begin
                bad++; $display("FAIL illegal_%0h: got err=%b halted=%b ab=%0d pc=%h want 01/1/0/001", op, ERR, HALTED, ab_cnt - ab_base, pc_reg);
            end
            $display("illegal op %0h: err=%b halted=%b", op, ERR, HALTED);
        end
    endtask

    task automatic test_ldx();
        bit hung;
        logic [11:0] val;
        fill_mem();
        val = 12'($urandom);
        mem[0] = 12'h2A5; mem[1] = 12'h030; mem[2] = 12'h7FF; mem[3] = 12'hF00;
        mem[12'h030] = val;
        model_run(); delay_mode = -1;
        run_prog(hung);
        total++; if (hung || a_reg !== val) begin bad++; $display("FAIL ldx_a: got %h want %h", a_reg, val); end
        total++; if (ind_cnt - ind_base < 1 || pc_reg !== 12'h004) begin bad++; $display("FAIL ldx_addr: got ind=%0d pc=%h want >=1/004", ind_cnt - ind_base, pc_reg); end
        total++; if (trace_mismatch() !== 0) begin bad++; $display("FAIL ldx_trace: got %0d mismatches want 0", trace_mismatch()); end
        $display("ldx: a=%h", a_reg);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        logic [11:0] outs;
        load_prog1(); delay_mode = 8;
        do_reset(); snap(); pulse_start();
        while (MEM_RD !== 1'b0 && n < 100) begin @(negedge CLK); n++; end
        while (MEM_RD !== 1'b1 && n < 100) begin @(negedge CLK); n++; end
        total++; if (n >= 100) begin bad++; $display("FAIL mid_reach_oper: got %0d cycles want <100", n); end
        START = 1'b1; @(negedge CLK); START = 1'b0;
        total++; if ({BUSY, MEM_RD, CTRL_ADDR} !== 3'b110) begin bad++; $display("FAIL mid_start_ignored: got %b want 110", {BUSY, MEM_RD, CTRL_ADDR}); end
        #2 RESET = 1'b1; #1;
        outs = {MEM_RD, CTRL_ADDR, CTRL_A, CTRL_PC, WE_A, WE_B, WE_PC, CIN, BUSY, HALTED, ERR};
        total++; if (outs !== 12'd0) begin bad++; $display("FAIL mid_reset_outputs: got %b want 0", outs); end
        @(negedge CLK); RESET = 1'b0;
        repeat (4) @(negedge CLK);
        total++; if ({BUSY, HALTED} !== 2'b00 || a_reg !== 12'd0) begin bad++; $display("FAIL mid_reset_idle: got busy=%b halted=%b a=%h want 0/0/000", BUSY, HALTED, a_reg); end
        $display("reset_mid: outputs=%b", outs);
    endtask

    task automatic test_random(input int iters);
        bit hung;
        int pos [0:16];
        logic [3:0] ops [0:15];
        int n, p;
        for (int it = 0; it < iters; it++) begin
            fill_mem();
            n = $urandom_range(3, 10);
            p = 0;
            for (int i = 0; i < n; i++) begin
                ops[i] = 4'($urandom_range(0, 7));
                pos[i] = p;
                mem[p] = {ops[i], 8'($urandom)};
                p += (ops[i] inside {4'h1, 4'h2, 4'h5, 4'h6}) ? 2 : 1;
            end
            pos[n] = p;
            mem[p] = ($urandom_range(0, 7) == 0) ? 12'hB00 : 12'hF00;
            for (int i = 0; i < n; i++) begin
                if (ops[i] == 4'h5 || ops[i] == 4'h6) mem[pos[i] + 1] = 12'(pos[$urandom_range(i + 1, n)]);
                if (ops[i] == 4'h2) mem[pos[i] + 1] = 12'h800 | 12'($urandom_range(0, 255));
            end
            model_run(); delay_mode = -1;
            run_prog(hung);
            total++; if (hung || HALTED !== 1'b1) begin bad++; $display("FAIL rand%0d_halt: got halted=%b want 1", it, HALTED); end
            total++; if ({a_reg, b_reg, pc_reg} !== {exp_a, exp_b, exp_pc}) begin
                bad++; $display("FAIL rand%0d_regs: got a=%h b=%h pc=%h want a=%h b=%h pc=%h", it, a_reg, b_reg, pc_reg, exp_a, exp_b, exp_pc);
            end
            total++; if (ERR !== exp_err) begin bad++; $display("FAIL rand%0d_err: got %b want %b", it, ERR, exp_err); end
            total++; if (trace_mismatch() !== 0 || jump_cnt - jmp_base !== exp_jumps || wait_we_cnt - wwe_base !== 0) begin
                bad++; $display("FAIL rand%0d_trace: got mism=%0d jumps=%0d wait_we=%0d want 0/%0d/0", it, trace_mismatch(), jump_cnt - jmp_base, wait_we_cnt - wwe_base, exp_jumps);
            end
            $display("rand %0d: instrs=%0d a=%h b=%h pc=%h err=%b", it, n, a_reg, b_reg, pc_reg, ERR);
        end
    endtask

    initial begin
        test_reset();
        test_basic(0, "basic");
        test_carry();
        test_basic(3, "wait3");
        test_timeout();
        test_illegal();
        test_ldx();
        test_reset_mid();
        test_random(20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
